// File: rtl/sys_bus_pkg.sv
// Address-map defaults, I/O page offsets, STATUS/CTRL bit positions and region decode shared by the bus stage.
package sys_bus_pkg;

  localparam logic [15:0] RAM_TOP_DEF  = 16'h7FFF;
  localparam logic [15:0] IO_BASE_DEF  = 16'h8000;
  localparam logic [15:0] ROM_BASE_DEF = 16'hC000;

  localparam logic [7:0] OFF_TXDATA    = 8'h00;
  localparam logic [7:0] OFF_STATUS    = 8'h01;
  localparam logic [7:0] OFF_RELOAD_LO = 8'h02;
  localparam logic [7:0] OFF_RELOAD_HI = 8'h03;
  localparam logic [7:0] OFF_CTRL      = 8'h04;
  localparam logic [7:0] OFF_ACK       = 8'h05;
  localparam logic [7:0] OFF_COUNT_LO  = 8'h06;
  localparam logic [7:0] OFF_COUNT_HI  = 8'h07;
  // Unmapped offset used as the "no I/O write this cycle" selector
  localparam logic [7:0] OFF_NONE      = 8'hFF;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_FLAG   = 2;
  localparam int ST_OVF    = 3;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IEN  = 2;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_ROM  = 2'd1,
    REG_IO   = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  function automatic region_e decode_region(input logic [15:0] addr, input logic [15:0] ram_top,
                                            input logic [15:0] io_base, input logic [15:0] rom_base);
    region_e r;
    if (addr <= ram_top) r = REG_RAM;
    else if (addr >= rom_base) r = REG_ROM;
    else if (addr[15:8] == io_base[15:8]) r = REG_IO;
    else r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/sys_bus_ctrl_if.sv
// Core-facing bus plus RAM/ROM and TX-consumer signals of the system bus stage.
interface sys_bus_ctrl_if;
  import sys_bus_pkg::*;

  logic [15:0] address;
  logic [7:0]  wdata;
  logic        read_en;
  logic [7:0]  rdata;
  logic        ram_cs;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        rom_cs;
  logic [7:0]  rom_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  modport master (
    output address, wdata, read_en, ram_rdata, rom_rdata, tx_ready,
    input  rdata, ram_cs, ram_we, rom_cs, tx_data, tx_valid, irq
  );

  modport slave (
    input  address, wdata, read_en, ram_rdata, rom_rdata, tx_ready,
    output rdata, ram_cs, ram_we, rom_cs, tx_data, tx_valid, irq
  );
endinterface

// File: rtl/tx_fifo.sv
// Debug transmit byte FIFO with registered head byte and sticky overflow on push-while-full.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_ready_i,
  input  logic       clr_ovf_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [4:0] count_o,
  output logic       overflow_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, ovf_q, ovf_d;
  logic          full_s, pop_s, push_acc_s;

  assign full_s     = (count_q == DEPTH_C);
  assign pop_s      = tx_valid_q & pop_ready_i;
  assign push_acc_s = push_i & (~full_s | pop_s);

  // Next pointers, occupancy, overflow and the head byte that tx_data will show next cycle
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    tx_data_d = 8'h00;
    if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
    else rd_ptr_d = rd_ptr_q;
    if (push_acc_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else wr_ptr_d = wr_ptr_q;
    case ({push_acc_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr_ovf_i) ovf_d = 1'b0;
    else if (push_i & full_s & ~pop_s) ovf_d = 1'b1;
    else ovf_d = ovf_q;
    // A byte written into the slot that becomes the head must bypass the array
    if (count_d == {CW{1'b0}}) tx_data_d = 8'h00;
    else if (push_acc_s && (rd_ptr_d == wr_ptr_q)) tx_data_d = wdata_i;
    else tx_data_d = mem_q[rd_ptr_d];
  end

  // Control state and registered head byte
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= (count_d != {CW{1'b0}});
      ovf_q      <= ovf_d;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push_acc_s) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign full_o     = full_s;
  assign empty_o    = ~tx_valid_q;
  assign count_o    = 5'(count_q);
  assign overflow_o = ovf_q;
endmodule

// File: rtl/sys_bus_ctrl.sv
// System bus stage: RAM/ROM/I-O decode, read mux, TX FIFO and interval timer behind the 6502 core.
// Define SYS_BUS_TIMER_EN to build the timer; otherwise offsets 0x02-0x07 read 0 and irq is tied low.
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IO_BASE    = IO_BASE_DEF,
  parameter logic [15:0] ROM_BASE   = ROM_BASE_DEF,
  parameter logic [15:0] RAM_TOP    = RAM_TOP_DEF
) (
  input logic           ph2,
  input logic           reset,
  sys_bus_ctrl_if.slave bus
);
  region_e    region_s;
  logic       io_wr_s;
  logic [7:0] off_s, wr_off_s, io_rd_s, timer_rd_s, status_s, tx_data_s;
  logic       fifo_full_s, fifo_empty_s, fifo_ovf_s, tx_valid_s, flag_s;
  logic [4:0] fifo_cnt_s;
  logic [3:0] cnt_sat_s;

  assign region_s = decode_region(bus.address, RAM_TOP, IO_BASE, ROM_BASE);
  assign off_s    = bus.address[7:0];
  assign io_wr_s  = (region_s == REG_IO) & ~bus.read_en;
  assign wr_off_s = io_wr_s ? off_s : OFF_NONE;

  assign bus.ram_cs = (region_s == REG_RAM);
  assign bus.rom_cs = (region_s == REG_ROM);
  assign bus.ram_we = (region_s == REG_RAM) & ~bus.read_en;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (ph2),
    .reset      (reset),
    .push_i     (wr_off_s == OFF_TXDATA),
    .pop_ready_i(bus.tx_ready),
    .clr_ovf_i  (wr_off_s == OFF_STATUS),
    .wdata_i    (bus.wdata),
    .tx_data_o  (tx_data_s),
    .tx_valid_o (tx_valid_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .count_o    (fifo_cnt_s),
    .overflow_o (fifo_ovf_s)
  );
  assign bus.tx_data  = tx_data_s;
  assign bus.tx_valid = tx_valid_s;

`ifdef SYS_BUS_TIMER_EN
  logic [15:0] reload_q, reload_d, tcount_q, tcount_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        flag_q, flag_d, irq_q, fire_s;

  assign fire_s = ctrl_q[CTRL_EN] & (tcount_q == 16'h0000);

  // Countdown/expiry first, then CPU writes so a same-cycle write overrides; ACK cannot beat a set
  always_comb begin
    reload_d = reload_q;
    tcount_d = tcount_q;
    ctrl_d   = ctrl_q;
    flag_d   = flag_q;
    if (fire_s) begin
      flag_d = 1'b1;
      if (ctrl_q[CTRL_AUTO]) tcount_d = reload_q;
      else ctrl_d[CTRL_EN] = 1'b0;
    end else if (ctrl_q[CTRL_EN]) begin
      tcount_d = tcount_q - 16'h0001;
    end else begin
      tcount_d = tcount_q;
    end
    case (wr_off_s)
      OFF_RELOAD_LO: reload_d[7:0] = bus.wdata;
      OFF_RELOAD_HI: begin
        reload_d[15:8] = bus.wdata;
        tcount_d       = {bus.wdata, reload_q[7:0]};
      end
      OFF_CTRL:      ctrl_d = bus.wdata[2:0];
      OFF_ACK:       flag_d = fire_s;
      default:       flag_d = flag_d;
    endcase
  end

  // Timer registers; irq is derived from next-state so it is purely registered
  always_ff @(posedge ph2) begin
    if (reset) begin
      reload_q <= 16'h0000;
      tcount_q <= 16'h0000;
      ctrl_q   <= 3'b000;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      reload_q <= reload_d;
      tcount_q <= tcount_d;
      ctrl_q   <= ctrl_d;
      flag_q   <= flag_d;
      irq_q    <= flag_d & ctrl_d[CTRL_IEN];
    end
  end

  always_comb begin
    timer_rd_s = 8'h00;
    case (off_s)
      OFF_RELOAD_LO: timer_rd_s = reload_q[7:0];
      OFF_RELOAD_HI: timer_rd_s = reload_q[15:8];
      OFF_CTRL:      timer_rd_s = {5'b00000, ctrl_q};
      OFF_COUNT_LO:  timer_rd_s = tcount_q[7:0];
      OFF_COUNT_HI:  timer_rd_s = tcount_q[15:8];
      default:       timer_rd_s = 8'h00;
    endcase
  end

  assign flag_s  = flag_q;
  assign bus.irq = irq_q;
`else
  assign timer_rd_s = 8'h00;
  assign flag_s     = 1'b0;
  assign bus.irq    = 1'b0;
`endif

  assign cnt_sat_s = (fifo_cnt_s > 5'd15) ? 4'hF : fifo_cnt_s[3:0];
  assign status_s  = {cnt_sat_s, fifo_ovf_s, flag_s, fifo_empty_s, fifo_full_s};

  // I/O page read mux: registered state only
  always_comb begin
    io_rd_s = 8'h00;
    case (off_s)
      OFF_STATUS:    io_rd_s = status_s;
      OFF_RELOAD_LO,
      OFF_RELOAD_HI,
      OFF_CTRL,
      OFF_COUNT_LO,
      OFF_COUNT_HI:  io_rd_s = timer_rd_s;
      default:       io_rd_s = 8'h00;
    endcase
  end

  // Read data returned to the core
  always_comb begin
    bus.rdata = 8'hFF;
    case (region_s)
      REG_RAM: bus.rdata = bus.ram_rdata;
      REG_ROM: bus.rdata = bus.rom_rdata;
      REG_IO:  bus.rdata = io_rd_s;
      default: bus.rdata = 8'hFF;
    endcase
  end
endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Directed bench for sys_bus_ctrl: queue/arithmetic reference model checked every cycle, plus literal spot checks.
module tb_sys_bus_ctrl;
  import sys_bus_pkg::*;

`ifdef SYS_BUS_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic ph2 = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  sys_bus_ctrl_if bus ();
  sys_bus_ctrl dut (.ph2(ph2), .reset(reset), .bus(bus));

  always #5 ph2 = ~ph2;

  // Reference state
  logic [7:0]  q[$];
  bit          m_ovf, m_en, m_auto, m_ien, m_flag;
  logic [15:0] m_reload, m_cnt;
  logic [20:0] exp_v, act_v;

  function automatic logic [7:0] m_io_read(input logic [7:0] off);
    int sz;
    sz = q.size();
    case (off)
      8'h01:   return {((sz > 15) ? 4'd15 : 4'(sz)), m_ovf, m_flag, (sz == 0), (sz == 4)};
      8'h02:   return m_reload[7:0];
      8'h03:   return m_reload[15:8];
      8'h04:   return {5'b00000, m_ien, m_auto, m_en};
      8'h06:   return m_cnt[7:0];
      8'h07:   return m_cnt[15:8];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_rdata(input logic [15:0] a);
    if (a <= 16'h7FFF) return bus.ram_rdata;
    if (a >= 16'hC000) return bus.rom_rdata;
    if (a[15:8] == 8'h80) return m_io_read(a[7:0]);
    return 8'hFF;
  endfunction

  task automatic model_step();
    logic [15:0] a;
    logic [7:0]  off;
    bit          wr_io, pop, fire;
    int          sz0;
    a     = bus.address;
    off   = a[7:0];
    wr_io = !bus.read_en && (a[15:8] == 8'h80);
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_en = 1'b0; m_auto = 1'b0; m_ien = 1'b0; m_flag = 1'b0;
      m_reload = 16'h0000; m_cnt = 16'h0000;
    end else begin
      sz0 = q.size();
      pop = (sz0 != 0) && bus.tx_ready;
      if (pop) void'(q.pop_front());
      if (wr_io && off == 8'h00) begin
        if (sz0 < 4 || pop) q.push_back(bus.wdata);
        else m_ovf = 1'b1;
      end
      if (wr_io && off == 8'h01) m_ovf = 1'b0;
      if (TIMER_EN) begin
        fire = m_en && (m_cnt == 16'h0000);
        if (fire) begin
          m_flag = 1'b1;
          if (m_auto) m_cnt = m_reload;
          else m_en = 1'b0;
        end else if (m_en) begin
          m_cnt = m_cnt - 16'h0001;
        end
        if (wr_io) begin
          case (off)
            8'h02: m_reload[7:0] = bus.wdata;
            8'h03: begin m_cnt = {bus.wdata, m_reload[7:0]}; m_reload[15:8] = bus.wdata; end
            8'h04: begin m_en = bus.wdata[0]; m_auto = bus.wdata[1]; m_ien = bus.wdata[2]; end
            8'h05: if (!fire) m_flag = 1'b0;
            default: ;
          endcase
        end
      end
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge ph2) begin
    if (chk_en) begin
      exp_v = {m_rdata(bus.address), (bus.address <= 16'h7FFF),
               (bus.address <= 16'h7FFF) && !bus.read_en, (bus.address >= 16'hC000),
               (q.size() != 0), ((q.size() != 0) ? q[0] : 8'h00), m_flag && m_ien};
      act_v = {bus.rdata, bus.ram_cs, bus.ram_we, bus.rom_cs, bus.tx_valid, bus.tx_data, bus.irq};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle a=%h: got {rdata,cs/we,rom,txv,txd,irq}=%h required %h", bus.address, act_v, exp_v);
      end
    end
  end

  task automatic hchk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic rdy);
    bus.address  = a;
    bus.wdata    = d;
    bus.read_en  = rd;
    bus.tx_ready = rdy;
  endtask

  task automatic tick();
    @(posedge ph2);
    model_step();
    #2;
  endtask

  initial begin
    bus.ram_rdata = 8'h5A;
    bus.rom_rdata = 8'hC3;
    reset = 1'b1;
    drive(16'h0000, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    drive(16'h8001, 8'h00, 1'b1, 1'b0); #1;
    hchk("status_rst", bus.rdata, 8'h02);
    hchk("txv_rst", {7'b0, bus.tx_valid}, 8'h00);
    tick();

    // Decode sweep
    drive(16'h1234, 8'h00, 1'b1, 1'b0); #1;
    hchk("ram_rd", bus.rdata, 8'h5A);
    hchk("ram_cs", {7'b0, bus.ram_cs}, 8'h01);
    tick();
    bus.rom_rdata = 8'h00;
    drive(16'hFFFC, 8'h00, 1'b1, 1'b0); #1;
    hchk("rom_cs", {7'b0, bus.rom_cs}, 8'h01);
    hchk("rom_rd", bus.rdata, 8'h00);
    tick();
    bus.rom_rdata = 8'hC3;
    drive(16'hA000, 8'h00, 1'b1, 1'b0); #1;
    hchk("open_rd", bus.rdata, 8'hFF);
    hchk("open_cs", {6'b0, bus.ram_cs, bus.rom_cs}, 8'h00);
    tick();
    drive(16'hD000, 8'h77, 1'b0, 1'b0); #1;
    hchk("rom_we", {7'b0, bus.ram_we}, 8'h00);
    tick();
    drive(16'h1000, 8'h77, 1'b0, 1'b0); #1;
    hchk("ram_we", {7'b0, bus.ram_we}, 8'h01);
    tick();

    // FIFO overflow and ordered drain
    for (int i = 0; i < 5; i++) begin drive(16'h8000, 8'(8'h41 + i), 1'b0, 1'b0); tick(); end
    drive(16'h8001, 8'h00, 1'b1, 1'b0); #1;
    hchk("status_ovf", bus.rdata, 8'h49);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(16'h0000, 8'h00, 1'b1, 1'b1); #1;
      hchk("drain", bus.tx_data, 8'(8'h41 + i));
      tick();
    end
    drive(16'h0000, 8'h00, 1'b1, 1'b1); #1;
    hchk("drained", {7'b0, bus.tx_valid}, 8'h00);
    tick();
    drive(16'h8001, 8'h00, 1'b0, 1'b0); tick();
    drive(16'h8001, 8'h00, 1'b1, 1'b0); #1;
    hchk("ovf_clr", bus.rdata, 8'h02);
    tick();

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin drive(16'h8000, 8'(8'h10 + i), 1'b0, 1'b0); tick(); end
    drive(16'h8001, 8'h00, 1'b1, 1'b0); #1;
    hchk("status_full", bus.rdata, 8'h41);
    tick();
    drive(16'h8000, 8'h14, 1'b0, 1'b1); tick();
    drive(16'h8001, 8'h00, 1'b1, 1'b0); #1;
    hchk("status_pushpop", bus.rdata, 8'h41);
    hchk("head_pushpop", bus.tx_data, 8'h11);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(16'h0000, 8'h00, 1'b1, 1'b1); #1;
      hchk("drain2", bus.tx_data, 8'(8'h11 + i));
      tick();
    end

    // Timer one-shot
    drive(16'h8002, 8'h03, 1'b0, 1'b0); tick();
    drive(16'h8003, 8'h00, 1'b0, 1'b0); tick();
    drive(16'h8004, 8'h05, 1'b0, 1'b0); tick();
    drive(16'h8006, 8'h00, 1'b1, 1'b0); #1;
    hchk("cnt_lo", bus.rdata, TIMER_EN ? 8'h03 : 8'h00);
    tick();
    drive(16'h0000, 8'h00, 1'b1, 1'b0); tick();
    drive(16'h0000, 8'h00, 1'b1, 1'b0); tick();
    drive(16'h0000, 8'h00, 1'b1, 1'b0); #1;
    hchk("irq_early", {7'b0, bus.irq}, 8'h00);
    tick();
    drive(16'h8004, 8'h00, 1'b1, 1'b0); #1;
    hchk("irq_oneshot", {7'b0, bus.irq}, TIMER_EN ? 8'h01 : 8'h00);
    hchk("ctrl_oneshot", bus.rdata, TIMER_EN ? 8'h04 : 8'h00);
    tick();
    drive(16'h8001, 8'h00, 1'b1, 1'b0); #1;
    hchk("status_flag", bus.rdata, TIMER_EN ? 8'h06 : 8'h02);
    tick();
    drive(16'h8005, 8'h00, 1'b0, 1'b0); tick();
    drive(16'h0000, 8'h00, 1'b1, 1'b0); #1;
    hchk("irq_ack", {7'b0, bus.irq}, 8'h00);
    tick();

    // Timer auto-reload, ACK coincident with a set
    drive(16'h8002, 8'h02, 1'b0, 1'b0); tick();
    drive(16'h8003, 8'h00, 1'b0, 1'b0); tick();
    drive(16'h8004, 8'h07, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin drive(16'h0000, 8'h00, 1'b1, 1'b0); tick(); end
    drive(16'h8005, 8'h00, 1'b0, 1'b0); #1;
    hchk("irq_auto1", {7'b0, bus.irq}, TIMER_EN ? 8'h01 : 8'h00);
    tick();
    drive(16'h0000, 8'h00, 1'b1, 1'b0); #1;
    hchk("irq_auto_ack", {7'b0, bus.irq}, 8'h00);
    tick();
    drive(16'h8005, 8'h00, 1'b0, 1'b0); tick();
    drive(16'h0000, 8'h00, 1'b1, 1'b0); #1;
    hchk("irq_ack_race", {7'b0, bus.irq}, TIMER_EN ? 8'h01 : 8'h00);
    tick();

    // Reset mid-countdown with bytes queued
    drive(16'h8000, 8'hA1, 1'b0, 1'b0); tick();
    drive(16'h8000, 8'hA2, 1'b0, 1'b0); tick();
    reset = 1'b1;
    drive(16'h0000, 8'h00, 1'b1, 1'b0); tick();
    reset = 1'b0;
    drive(16'h8006, 8'h00, 1'b1, 1'b0); #1;
    hchk("rst_txv", {7'b0, bus.tx_valid}, 8'h00);
    hchk("rst_irq", {7'b0, bus.irq}, 8'h00);
    hchk("rst_cnt", bus.rdata, 8'h00);
    tick();
    drive(16'h8004, 8'h00, 1'b1, 1'b0); #1;
    hchk("rst_ctrl", bus.rdata, 8'h00);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
